md_unit: RTL and testbench



---
 rtl/md_unit.sv | 120 ++++++++++++
 tb/tb_md_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at accept, staged, and committed when the busy counter expires.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] numa,
  input  logic [31:0] numb,
  input  logic [2:0]  mdop,
  input  logic        mdvalid,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   st_hi_q, st_hi_d;
  logic [31:0]   st_lo_q, st_lo_d;
  logic          st_wr_q, st_wr_d;

  logic [63:0] prod_s, prod_u;
  logic        div_signed, neg_a, neg_b;
  logic [31:0] mag_a, mag_b, quot_u, rem_u, quot, rem;

  always_comb begin
    prod_s = {{32{numa[31]}}, numa} * {{32{numb[31]}}, numb};
    prod_u = {32'd0, numa} * {32'd0, numb};
  end

  // Signed divide works on magnitudes so that 0x80000000 / -1 wraps cleanly.
  always_comb begin
    div_signed = (mdop == OP_DIV);
    neg_a      = div_signed & numa[31];
    neg_b      = div_signed & numb[31];
    mag_a      = neg_a ? (32'd0 - numa) : numa;
    mag_b      = neg_b ? (32'd0 - numb) : numb;
    quot_u     = (mag_b == 32'd0) ? 32'd0 : (mag_a / mag_b);
    rem_u      = (mag_b == 32'd0) ? 32'd0 : (mag_a % mag_b);
    quot       = (neg_a ^ neg_b) ? (32'd0 - quot_u) : quot_u;
    rem        = neg_a ? (32'd0 - rem_u) : rem_u;
  end

  always_comb begin
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    st_hi_d = st_hi_q;
    st_lo_d = st_lo_q;
    st_wr_d = st_wr_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1) && st_wr_q) begin
        hi_d = st_hi_q;
        lo_d = st_lo_q;
      end
    end else if (mdvalid) begin
      case (mdop)
        OP_MULT: begin
          st_hi_d = prod_s[63:32];
          st_lo_d = prod_s[31:0];
          st_wr_d = 1'b1;
          cnt_d   = CW'(MULT_CYCLES);
        end
        OP_MULTU: begin
          st_hi_d = prod_u[63:32];
          st_lo_d = prod_u[31:0];
          st_wr_d = 1'b1;
          cnt_d   = CW'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          st_hi_d = rem;
          st_lo_d = quot;
          // A zero divisor still occupies the unit but leaves HI/LO untouched.
          st_wr_d = (numb != 32'd0);
          cnt_d   = CW'(DIV_CYCLES);
        end
        OP_MTHI: hi_d = numa;
        OP_MTLO: lo_d = numa;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      st_hi_q <= 32'd0;
      st_lo_q <= 32'd0;
      st_wr_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      st_hi_q <= st_hi_d;
      st_lo_q <= st_lo_d;
      st_wr_q <= st_wr_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized ops
// compared against an arithmetic reference model of HI/LO and busy latency.
module tb_md_unit;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] numa = 32'd0;
  logic [31:0] numb = 32'd0;
  logic [2:0]  mdop = 3'd7;
  logic        mdvalid = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_hi, exp_lo;

  md_unit #(.MULT_CYCLES(MULT_CYC), .DIV_CYCLES(DIV_CYC)) dut (
    .clk(clk), .reset(reset), .numa(numa), .numb(numb),
    .mdop(mdop), .mdvalid(mdvalid), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle, then scramble the operands.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mdop = op; numa = a; numb = b; mdvalid = 1'b1;
    tick();
    mdvalid = 1'b0;
    numa = $urandom; numb = $urandom; mdop = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  function automatic int exp_latency(input logic [2:0] op);
    if (op <= 3'd1) return MULT_CYC;
    if (op <= 3'd3) return DIV_CYC;
    return 0;
  endfunction

  // Reference model: architectural effect of one accepted op on HI/LO.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd1: begin up = ua * ub; exp_hi = up[63:32]; exp_lo = up[31:0]; end
      3'd2: if (b != 32'd0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
      3'd3: if (b != 32'd0) begin up = ua / ub; exp_lo = up[31:0]; up = ua % ub; exp_hi = up[31:0]; end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_hi got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_lo got %h want 00000000", lo); end
  endtask

  task automatic test_mult();
    int n;
    issue(3'd0, 32'hFFFFFFFF, 32'd2);
    wait_busy(n);
    n_checks++; if (n != 5) begin n_fail++; $display("[TB] FAIL mult_latency got %0d want 5", n); end
    n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL mult_hi got %h want ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFFFFFE) begin n_fail++; $display("[TB] FAIL mult_lo got %h want fffffffe", lo); end
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    wait_busy(n);
    n_checks++; if (n != 5) begin n_fail++; $display("[TB] FAIL multu_latency got %0d want 5", n); end
    n_checks++; if (hi !== 32'h00000001) begin n_fail++; $display("[TB] FAIL multu_hi got %h want 00000001", hi); end
    n_checks++; if (lo !== 32'hFFFFFFFE) begin n_fail++; $display("[TB] FAIL multu_lo got %h want fffffffe", lo); end
  endtask

  task automatic test_div();
    int n;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_busy(n);
    n_checks++; if (n != 10) begin n_fail++; $display("[TB] FAIL div_latency got %0d want 10", n); end
    n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("[TB] FAIL div_lo got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL div_hi got %h want ffffffff", hi); end
    issue(3'd3, 32'd7, 32'd2);
    wait_busy(n);
    n_checks++; if (lo !== 32'd3) begin n_fail++; $display("[TB] FAIL divu_lo got %h want 00000003", lo); end
    n_checks++; if (hi !== 32'd1) begin n_fail++; $display("[TB] FAIL divu_hi got %h want 00000001", hi); end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_busy(n);
    n_checks++; if (lo !== 32'h80000000) begin n_fail++; $display("[TB] FAIL div_ovf_lo got %h want 80000000", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("[TB] FAIL div_ovf_hi got %h want 00000000", hi); end
  endtask

  task automatic test_div_zero();
    int n;
    issue(3'd4, 32'h11, 32'd0);
    issue(3'd5, 32'h22, 32'd0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mtx_busy got %b want 0", busy); end
    issue(3'd2, 32'h12345678, 32'd0);
    wait_busy(n);
    n_checks++; if (n != 10) begin n_fail++; $display("[TB] FAIL divzero_latency got %0d want 10", n); end
    n_checks++; if (hi !== 32'h11) begin n_fail++; $display("[TB] FAIL divzero_hi got %h want 00000011", hi); end
    n_checks++; if (lo !== 32'h22) begin n_fail++; $display("[TB] FAIL divzero_lo got %h want 00000022", lo); end
  endtask

  task automatic test_ignore_busy();
    int n;
    issue(3'd4, 32'h1234, 32'd0);
    n_checks++; if (hi !== 32'h1234) begin n_fail++; $display("[TB] FAIL mthi_hi got %h want 00001234", hi); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mthi_busy got %b want 0", busy); end
    issue(3'd0, 32'd3, 32'd4);
    mdop = 3'd5; numa = 32'hDEAD; mdvalid = 1'b1;
    tick();
    mdop = 3'd0; numa = 32'd7; numb = 32'd9;
    tick();
    mdvalid = 1'b0;
    wait_busy(n);
    n_checks++; if (n + 2 != 5) begin n_fail++; $display("[TB] FAIL ignore_latency got %0d want 5", n + 2); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("[TB] FAIL ignore_hi got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'd12) begin n_fail++; $display("[TB] FAIL ignore_lo got %h want 0000000c", lo); end
  endtask

  task automatic test_reset_mid();
    issue(3'd4, 32'hAAAA, 32'd0);
    issue(3'd5, 32'h5555, 32'd0);
    issue(3'd2, 32'd100, 32'd7);
    for (int i = 0; i < 3; i++) begin
      numa = $urandom; numb = $urandom; mdop = 3'($urandom_range(0, 7)); mdvalid = 1'($urandom);
      tick();
    end
    mdvalid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("[TB] FAIL midreset_hi got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("[TB] FAIL midreset_lo got %h want 00000000", lo); end
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        n_fail++;
        $display("[TB] FAIL midreset_nocommit cycle %0d got busy=%b hi=%h lo=%h want 0/0/0", i, busy, hi, lo);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(3'd0, 32'd5, 32'd6);
    wait_busy(n);
    n_checks++; if (lo !== 32'd30) begin n_fail++; $display("[TB] FAIL b2b_mult_lo got %h want 0000001e", lo); end
    issue(3'd3, 32'd100, 32'd7);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_accept got busy=%b want 1", busy); end
    wait_busy(n);
    n_checks++; if (n != 10) begin n_fail++; $display("[TB] FAIL b2b_latency got %0d want 10", n); end
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("[TB] FAIL b2b_lo got %h want 0000000e", lo); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("[TB] FAIL b2b_hi got %h want 00000002", hi); end
    exp_hi = 32'd2;
    exp_lo = 32'd14;
  endtask

  task automatic test_random();
    int n;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) b = 32'd0;
      if (i % 7 == 3) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if (i % 6 == 1) b = 32'($urandom_range(1, 9));
      issue(op, a, b);
      model_op(op, a, b);
      if (exp_latency(op) > 0) begin
        wait_busy(n);
        n_checks++; if (n != exp_latency(op)) begin n_fail++; $display("[TB] FAIL rand_latency op=%0d got %0d want %0d", op, n, exp_latency(op)); end
      end else begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_busy op=%0d got %b want 0", op, busy); end
      end
      n_checks++; if (hi !== exp_hi) begin n_fail++; $display("[TB] FAIL rand_hi op=%0d a=%h b=%h got %h want %h", op, a, b, hi, exp_hi); end
      n_checks++; if (lo !== exp_lo) begin n_fail++; $display("[TB] FAIL rand_lo op=%0d a=%h b=%h got %h want %h", op, a, b, lo, exp_lo); end
    end
  endtask

  initial begin
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    tick();
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
